// File: rtl/dcache_refill_ctrl.sv
// Data-cache refill controller: optional dirty-victim writeback, then line read and refill.
// Optional watchdog under `DCACHE_TIMEOUT_EN` (adds refill_err and TIMEOUT_CYCLES counter).
`ifndef MEM_ADDRESS_LEN
`define MEM_ADDRESS_LEN 32
`endif
`ifndef MEM_LINE_WIDTH
`define MEM_LINE_WIDTH 128
`endif

module dcache_refill_ctrl #(
    parameter int ADDR_W         = `MEM_ADDRESS_LEN,
    parameter int LINE_W         = `MEM_LINE_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              evict_dirty,
    input  logic [ADDR_W-1:0] evict_addr,
    input  logic [LINE_W-1:0] evict_data,
    output logic              refill_valid,
    output logic [ADDR_W-1:0] refill_addr,
    output logic [LINE_W-1:0] refill_data,
    output logic              busy,
`ifdef DCACHE_TIMEOUT_EN
    output logic              refill_err,
`endif
    output logic              from_dcache,
    output logic              is_write,
    output logic [ADDR_W-1:0] addr_dcache,
    output logic [ADDR_W-1:0] write_addr,
    output logic [LINE_W-1:0] data_from_cache,
    input  logic [LINE_W-1:0] data_to_cache,
    input  logic              read_ready_for_dcache,
    input  logic              written_data_ack
);

    typedef enum logic [1:0] {IDLE, WB, RD, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
    logic [ADDR_W-1:0] evict_addr_q, evict_addr_d;
    logic [LINE_W-1:0] evict_data_q, evict_data_d;
    logic              capture;

`ifdef DCACHE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout;
`endif

    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        evict_addr_d = evict_addr_q;
        evict_data_d = evict_data_q;
        capture      = 1'b0;
        // Responses that do not belong to the current phase simply fall through.
        case (state_q)
            IDLE: if (miss_req) begin
                miss_addr_d  = miss_addr;
                evict_addr_d = evict_addr;
                evict_data_d = evict_data;
                state_d      = evict_dirty ? WB : RD;
            end
            WB:   if (written_data_ack) state_d = RD;
            RD:   if (read_ready_for_dcache) begin
                state_d = DONE;
                capture = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef DCACHE_TIMEOUT_EN
        timeout = 1'b0;
        cnt_d   = cnt_q;
        // A response on the final cycle wins over the watchdog.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == WB || state_q == RD) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                timeout = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            miss_addr_q     <= '0;
            evict_addr_q    <= '0;
            evict_data_q    <= '0;
            from_dcache     <= 1'b0;
            is_write        <= 1'b0;
            addr_dcache     <= '0;
            write_addr      <= '0;
            data_from_cache <= '0;
            refill_valid    <= 1'b0;
            refill_addr     <= '0;
            refill_data     <= '0;
            busy            <= 1'b0;
`ifdef DCACHE_TIMEOUT_EN
            cnt_q           <= '0;
            refill_err      <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            miss_addr_q     <= miss_addr_d;
            evict_addr_q    <= evict_addr_d;
            evict_data_q    <= evict_data_d;
            // Outputs are decoded from next state so they are registered yet cycle-aligned.
            from_dcache     <= (state_d == WB) || (state_d == RD);
            is_write        <= state_d == WB;
            addr_dcache     <= (state_d == RD) ? miss_addr_d : '0;
            write_addr      <= (state_d == WB) ? evict_addr_d : '0;
            data_from_cache <= (state_d == WB) ? evict_data_d : '0;
            refill_valid    <= state_d == DONE;
            refill_addr     <= (state_d == DONE) ? miss_addr_d : '0;
            if (capture) refill_data <= data_to_cache;
            busy            <= state_d != IDLE;
`ifdef DCACHE_TIMEOUT_EN
            cnt_q           <= cnt_d;
            refill_err      <= timeout;
`endif
        end
    end

endmodule
